// File: rtl/color_pkg.sv
// Shared types and constants for the palette colour stage.
package color_pkg;

    localparam int CHAN_W  = 8;
    localparam int LATENCY = 2;

    typedef struct packed {
        logic [CHAN_W-1:0] r;
        logic [CHAN_W-1:0] g;
        logic [CHAN_W-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } fade_state_e;

endpackage

// File: rtl/palette_color_mapper_if.sv
// Pixel, palette-write and fade-control bundle between the generators and the colour stage.
interface palette_color_mapper_if #(
    parameter int NUM_LAYERS = 4,
    parameter int IDX_W      = 4,
    parameter int COORD_W    = 10,
    parameter int CHAN_W     = color_pkg::CHAN_W
);
    logic [COORD_W-1:0]          draw_x;
    logic [COORD_W-1:0]          draw_y;
    logic                        pix_valid;
    logic                        frame_start;
    logic [NUM_LAYERS-1:0]       layer_on;
    logic [NUM_LAYERS*IDX_W-1:0] layer_idx;
    logic                        pal_we;
    logic [IDX_W-1:0]            pal_waddr;
    logic [3*CHAN_W-1:0]         pal_wdata;
    logic                        fade_req;
    logic                        fade_dir;
    logic                        fade_busy;
    logic [CHAN_W-1:0]           red;
    logic [CHAN_W-1:0]           green;
    logic [CHAN_W-1:0]           blue;
    logic                        out_valid;

    modport master (
        output draw_x, draw_y, pix_valid, frame_start, layer_on, layer_idx,
               pal_we, pal_waddr, pal_wdata, fade_req, fade_dir,
        input  fade_busy, red, green, blue, out_valid
    );

    modport slave (
        input  draw_x, draw_y, pix_valid, frame_start, layer_on, layer_idx,
               pal_we, pal_waddr, pal_wdata, fade_req, fade_dir,
        output fade_busy, red, green, blue, out_valid
    );
endinterface

// File: rtl/palette_ram.sv
// Writable RGB palette: one write port, registered read with write-first bypass,
// cleared synchronously on reset.
module palette_ram
    import color_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  rgb_t             wdata,
    input  logic [IDX_W-1:0] raddr,
    output rgb_t             rdata
);
    localparam int DEPTH = 2 ** IDX_W;

    rgb_t mem_r [DEPTH];
    rgb_t rdata_r;

    // Storage write, clear and registered read with same-address bypass.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            rdata_r <= '0;
        end else begin
            if (we) begin
                mem_r[waddr] <= wdata;
            end
            rdata_r <= (we && (waddr == raddr)) ? wdata : mem_r[raddr];
        end
    end

    assign rdata = rdata_r;
endmodule

// File: rtl/palette_color_mapper.sv
// Two-stage pixel colour pipe: priority layer select, palette lookup or gradient
// background, frame-locked fade and blanking.
module palette_color_mapper #(
    parameter int NUM_LAYERS      = 4,
    parameter int IDX_W           = 4,
    parameter int COORD_W         = 10,
    parameter int CHAN_W          = color_pkg::CHAN_W,
    parameter int FRAMES_PER_STEP = 4
) (
    input logic                    clk,
    input logic                    reset,
    palette_color_mapper_if.slave  bus
);
    import color_pkg::*;

    localparam int LVL_W = $clog2(CHAN_W + 1);
    localparam int CNT_W = $clog2(FRAMES_PER_STEP + 1);

    fade_state_e         state_r;
    logic                busy_r;
    logic [LVL_W-1:0]    level_r;
    logic [CNT_W-1:0]    cnt_r;

    logic                hit_s;
    logic [IDX_W-1:0]    idx_s;
    logic                hit_r;
    logic [IDX_W-1:0]    idx_r;
    logic [CHAN_W-2:0]   bgx_r;
    logic                valid_r;

    rgb_t                ram_rdata_s;
    rgb_t                pal_s;
    rgb_t                col_s;
    logic [CHAN_W-1:0]   red_r;
    logic [CHAN_W-1:0]   green_r;
    logic [CHAN_W-1:0]   blue_r;
    logic                out_valid_r;
    logic                unused_ok_s;

    // Only the top bits of draw_x feed the gradient; draw_y never affects colour.
    assign unused_ok_s = ^{bus.draw_y, bus.draw_x};

    // Winner is the lowest-numbered layer that is on with a non-transparent index.
    always_comb begin
        hit_s = 1'b0;
        idx_s = {IDX_W{1'b0}};
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (bus.layer_on[k] && (bus.layer_idx[k*IDX_W +: IDX_W] != {IDX_W{1'b0}})) begin
                hit_s = 1'b1;
                idx_s = bus.layer_idx[k*IDX_W +: IDX_W];
            end else begin
                hit_s = hit_s;
                idx_s = idx_s;
            end
        end
    end

    // The RAM read is launched from the S1 winner so its data is ready in S2.
    palette_ram #(.IDX_W(IDX_W)) u_palette_ram (
        .clk   (clk),
        .reset (reset),
        .we    (bus.pal_we),
        .waddr (bus.pal_waddr),
        .wdata (rgb_t'(bus.pal_wdata)),
        .raddr (idx_s),
        .rdata (ram_rdata_s)
    );

    // S1 pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_r   <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
            bgx_r   <= {(CHAN_W-1){1'b0}};
            valid_r <= 1'b0;
        end else begin
            hit_r   <= hit_s;
            idx_r   <= idx_s;
            bgx_r   <= bus.draw_x[COORD_W-1 -: CHAN_W-1];
            valid_r <= bus.pix_valid;
        end
    end

    // S2 colour: a write landing while S2 reads the same entry wins over the RAM data.
    always_comb begin
        pal_s = ram_rdata_s;
        col_s = '0;
        if (bus.pal_we && (bus.pal_waddr == idx_r)) begin
            pal_s = rgb_t'(bus.pal_wdata);
        end else begin
            pal_s = ram_rdata_s;
        end
        if (hit_r) begin
            col_s = pal_s;
        end else begin
            col_s.r = {CHAN_W{1'b0}};
            col_s.g = {CHAN_W{1'b0}};
            col_s.b = {1'b0, {(CHAN_W-1){1'b1}}} - {1'b0, bgx_r};
        end
    end

    // S2 output registers with fade shift and blanking.
    always_ff @(posedge clk) begin
        if (reset) begin
            red_r       <= {CHAN_W{1'b0}};
            green_r     <= {CHAN_W{1'b0}};
            blue_r      <= {CHAN_W{1'b0}};
            out_valid_r <= 1'b0;
        end else if (valid_r) begin
            red_r       <= col_s.r >> level_r;
            green_r     <= col_s.g >> level_r;
            blue_r      <= col_s.b >> level_r;
            out_valid_r <= 1'b1;
        end else begin
            red_r       <= {CHAN_W{1'b0}};
            green_r     <= {CHAN_W{1'b0}};
            blue_r      <= {CHAN_W{1'b0}};
            out_valid_r <= 1'b0;
        end
    end

    // Fade FSM: the level only moves on frame_start, so a frame never tears.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            level_r <= {LVL_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.fade_req && bus.fade_dir && (level_r < LVL_W'(CHAN_W))) begin
                        state_r <= FADE_OUT;
                        busy_r  <= 1'b1;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else if (bus.fade_req && !bus.fade_dir && (level_r != {LVL_W{1'b0}})) begin
                        state_r <= FADE_IN;
                        busy_r  <= 1'b1;
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                end
                FADE_OUT: begin
                    if (bus.frame_start) begin
                        if (cnt_r == CNT_W'(FRAMES_PER_STEP - 1)) begin
                            cnt_r   <= {CNT_W{1'b0}};
                            level_r <= level_r + 1'b1;
                            if (level_r == LVL_W'(CHAN_W - 1)) begin
                                state_r <= IDLE;
                                busy_r  <= 1'b0;
                            end
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                end
                FADE_IN: begin
                    if (bus.frame_start) begin
                        if (cnt_r == CNT_W'(FRAMES_PER_STEP - 1)) begin
                            cnt_r   <= {CNT_W{1'b0}};
                            level_r <= level_r - 1'b1;
                            if (level_r == {{(LVL_W-1){1'b0}}, 1'b1}) begin
                                state_r <= IDLE;
                                busy_r  <= 1'b0;
                            end
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.red       = red_r;
    assign bus.green     = green_r;
    assign bus.blue      = blue_r;
    assign bus.out_valid = out_valid_r;
    assign bus.fade_busy = busy_r;
endmodule

// File: tb/tb_palette_color_mapper.sv
// Directed bench for palette_color_mapper with hand-computed expected colours.
module tb_palette_color_mapper;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    palette_color_mapper_if bus ();

    palette_color_mapper dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    wire [23:0] rgb = {bus.red, bus.green, bus.blue};

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pal_write(input logic [3:0] addr, input logic [23:0] data);
        bus.pal_we    = 1'b1;
        bus.pal_waddr = addr;
        bus.pal_wdata = data;
        tick(1);
        bus.pal_we    = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            bus.frame_start = 1'b1;
            tick(1);
            bus.frame_start = 1'b0;
            tick(1);
        end
    endtask

    task automatic test_reset;
        bus.draw_x = 10'd80; bus.draw_y = 10'd5; bus.pix_valid = 1'b1;
        bus.frame_start = 1'b0; bus.layer_on = 4'b0000; bus.layer_idx = 16'h0000;
        bus.pal_we = 1'b0; bus.pal_waddr = 4'd0; bus.pal_wdata = 24'h000000;
        bus.fade_req = 1'b0; bus.fade_dir = 1'b0;
        reset = 1'b1;
        tick(2);
        total++;
        if (rgb !== 24'h000000 || bus.out_valid !== 1'b0 || bus.fade_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got rgb=%h ov=%b busy=%b want 000000/0/0", rgb, bus.out_valid, bus.fade_busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_background;
        bus.draw_x = 10'd80; bus.layer_on = 4'b0000; bus.pix_valid = 1'b1;
        tick(2);
        total++;
        if (rgb !== 24'h000075 || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL bg_x80 got rgb=%h ov=%b want 000075/1", rgb, bus.out_valid);
        end
        bus.draw_x = 10'd0;
        tick(1);
        bus.draw_x = 10'd1023;
        tick(1);
        total++;
        if (rgb !== 24'h00007f) begin
            bad++;
            $display("FAIL bg_x0 got %h want 00007f", rgb);
        end
        tick(1);
        total++;
        if (rgb !== 24'h000000 || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL bg_x1023 got rgb=%h ov=%b want 000000/1", rgb, bus.out_valid);
        end
    endtask

    task automatic test_priority;
        pal_write(4'd3, 24'hFF8000);
        bus.layer_on = 4'b0110; bus.layer_idx = 16'h0530;
        tick(2);
        total++;
        if (rgb !== 24'hFF8000) begin
            bad++;
            $display("FAIL priority got %h want ff8000", rgb);
        end
    endtask

    task automatic test_transparency;
        pal_write(4'd5, 24'h00FF00);
        bus.layer_on = 4'b0110; bus.layer_idx = 16'h0503;
        tick(2);
        total++;
        if (rgb !== 24'h00FF00) begin
            bad++;
            $display("FAIL transparency got %h want 00ff00", rgb);
        end
    endtask

    task automatic test_write_first;
        bus.layer_on = 4'b0010; bus.layer_idx = 16'h0030;
        tick(1);
        pal_write(4'd3, 24'h123456);
        total++;
        if (rgb !== 24'h123456) begin
            bad++;
            $display("FAIL write_first_s2 got %h want 123456", rgb);
        end
        tick(1);
        pal_write(4'd3, 24'hABCDEF);
        tick(1);
        total++;
        if (rgb !== 24'hABCDEF) begin
            bad++;
            $display("FAIL write_first_s1 got %h want abcdef", rgb);
        end
    endtask

    task automatic test_fade;
        pal_write(4'd3, 24'hFF8000);
        bus.layer_on = 4'b0010; bus.layer_idx = 16'h0030; bus.pix_valid = 1'b1;
        tick(2);
        bus.fade_req = 1'b1; bus.fade_dir = 1'b1; bus.frame_start = 1'b1;
        tick(1);
        bus.fade_req = 1'b0; bus.frame_start = 1'b0;
        total++;
        if (bus.fade_busy !== 1'b1) begin
            bad++;
            $display("FAIL fade_accept busy got %b want 1", bus.fade_busy);
        end
        frames(3);
        tick(2);
        total++;
        if (rgb !== 24'hFF8000) begin
            bad++;
            $display("FAIL fade_3_pulses got %h want ff8000", rgb);
        end
        frames(1);
        tick(2);
        total++;
        if (rgb !== 24'h7F4000) begin
            bad++;
            $display("FAIL fade_level1 got %h want 7f4000", rgb);
        end
        bus.fade_req = 1'b1; bus.fade_dir = 1'b0;
        tick(1);
        bus.fade_req = 1'b0;
        frames(24);
        tick(2);
        total++;
        if (rgb !== 24'h010100 || bus.fade_busy !== 1'b1) begin
            bad++;
            $display("FAIL fade_level7 got rgb=%h busy=%b want 010100/1", rgb, bus.fade_busy);
        end
        frames(3);
        total++;
        if (bus.fade_busy !== 1'b1) begin
            bad++;
            $display("FAIL fade_31_busy got %b want 1", bus.fade_busy);
        end
        frames(1);
        tick(2);
        total++;
        if (rgb !== 24'h000000 || bus.fade_busy !== 1'b0 || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL fade_black got rgb=%h busy=%b ov=%b want 000000/0/1", rgb, bus.fade_busy, bus.out_valid);
        end
        bus.fade_req = 1'b1; bus.fade_dir = 1'b1;
        tick(1);
        bus.fade_req = 1'b0;
        total++;
        if (bus.fade_busy !== 1'b0) begin
            bad++;
            $display("FAIL fade_at_target busy got %b want 0", bus.fade_busy);
        end
    endtask

    task automatic test_reset_mid_fade;
        bus.fade_req = 1'b1; bus.fade_dir = 1'b0;
        tick(1);
        bus.fade_req = 1'b0;
        frames(20);
        tick(2);
        total++;
        if (rgb !== 24'h1F1000 || bus.fade_busy !== 1'b1) begin
            bad++;
            $display("FAIL fade_in_level3 got rgb=%h busy=%b want 1f1000/1", rgb, bus.fade_busy);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        total++;
        if (rgb !== 24'h000000 || bus.fade_busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_fade got rgb=%h busy=%b ov=%b want 000000/0/0", rgb, bus.fade_busy, bus.out_valid);
        end
        bus.layer_on = 4'b0000; bus.draw_x = 10'd80;
        tick(2);
        total++;
        if (rgb !== 24'h000075) begin
            bad++;
            $display("FAIL level_cleared got %h want 000075", rgb);
        end
        bus.layer_on = 4'b0010; bus.layer_idx = 16'h0030;
        tick(2);
        total++;
        if (rgb !== 24'h000000 || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL palette_cleared got rgb=%h ov=%b want 000000/1", rgb, bus.out_valid);
        end
    endtask

    task automatic test_blanking;
        bus.layer_on = 4'b0000; bus.draw_x = 10'd80; bus.pix_valid = 1'b0;
        tick(2);
        total++;
        if (rgb !== 24'h000000 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL blanking got rgb=%h ov=%b want 000000/0", rgb, bus.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_background();
        test_priority();
        test_transparency();
        test_write_first();
        test_fade();
        test_reset_mid_fade();
        test_blanking();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
